// File: rtl/eyeriss_pe_core_p.sv
// eyeriss_pe_core_p: PE core that loads a map/filter row, runs a zero-gated MAC over NCH channels,
// folds in an incoming psum and hands back the narrowed result.
module eyeriss_pe_core_p #(
   parameter int DW = 16,
   parameter int NCH = 2,
   parameter int DEPTH = 12,
   parameter bit SAT = 1,
   parameter int LW = $clog2(DEPTH+1)
) (
   input  logic CLK,
   input  logic clr,
   input  logic start,
   input  logic [LW-1:0] cfg_len,
   input  logic [3:0] cfg_shift,
   input  logic map_valid,
   input  logic [DW-1:0] map_data,
   output logic map_ready,
   input  logic fil_valid,
   input  logic [NCH*DW-1:0] fil_data,
   output logic fil_ready,
   input  logic psum_in_valid,
   input  logic [NCH*DW-1:0] psum_in,
   output logic psum_in_ready,
   output logic out_valid,
   output logic [NCH*DW-1:0] out_data,
   input  logic out_ready,
   output logic busy,
   output logic done,
   output logic [LW-1:0] skip_count
);
   localparam int AW = 2*DW+LW;
   localparam int SW = AW+1;
   localparam logic signed [SW-1:0] MAXV = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [SW-1:0] MINV = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
   typedef enum logic [2:0] {IDLE, LOAD, MAC, ACCU, OUT} state_t;
   state_t state;
   logic [LW-1:0] len, len_c, map_cnt, fil_cnt, k;
   logic [3:0] shift;
   logic [DW-1:0] map_mem [DEPTH];
   logic [DW-1:0] fil_mem [NCH][DEPTH];
   logic signed [2*DW-1:0] prod [NCH];
   logic signed [2*DW-1:0] shifted [NCH];
   logic signed [AW-1:0] acc [NCH];
   logic signed [SW-1:0] total [NCH];
   logic [DW-1:0] narrowed [NCH];
   logic signed [DW-1:0] m_op;
   logic signed [DW-1:0] f_op [NCH];
   logic issue, zero_tap, map_fire, fil_fire, pv, pskip;
   assign map_ready = state == LOAD && map_cnt < len;
   assign fil_ready = state == LOAD && fil_cnt < len;
   assign psum_in_ready = state == ACCU;
   assign out_valid = state == OUT;
   assign busy = state != IDLE;
   always_comb begin
      len_c = cfg_len > LW'(DEPTH) ? LW'(DEPTH) : cfg_len;
      issue = state == MAC && k < len;
      zero_tap = map_mem[k] == '0;
      map_fire = map_ready && map_valid;
      fil_fire = fil_ready && fil_valid;
      m_op = issue && !zero_tap ? map_mem[k] : '0;
      for (int c = 0; c < NCH; c++) begin
         f_op[c] = issue && !zero_tap ? fil_mem[c][k] : '0;
         shifted[c] = prod[c] >>> shift;
         total[c] = $signed({acc[c][AW-1], acc[c]}) + $signed({{(SW-DW){psum_in[c*DW+DW-1]}}, psum_in[c*DW +: DW]});
         narrowed[c] = SAT && total[c] > MAXV ? MAXV[DW-1:0] : SAT && total[c] < MINV ? MINV[DW-1:0] : total[c][DW-1:0];
      end
   end
   // scratchpads carry no reset; every LOAD rewrites the entries it uses
   always_ff @(posedge CLK) begin
      if (map_fire) map_mem[map_cnt] <= map_data;
      if (fil_fire)
         for (int c = 0; c < NCH; c++) fil_mem[c][fil_cnt] <= fil_data[c*DW +: DW];
   end
   always_ff @(posedge CLK) begin
      if (clr) begin
         state <= IDLE;
         len <= '0;
         shift <= '0;
         map_cnt <= '0;
         fil_cnt <= '0;
         k <= '0;
         skip_count <= '0;
         out_data <= '0;
         done <= 1'b0;
         pv <= 1'b0;
         pskip <= 1'b0;
         for (int c = 0; c < NCH; c++) begin
            prod[c] <= '0;
            acc[c] <= '0;
         end
      end else begin
         done <= 1'b0;
         pv <= issue;
         pskip <= issue && zero_tap;
         for (int c = 0; c < NCH; c++) begin
            prod[c] <= m_op * f_op[c];
            if (pv && !pskip) acc[c] <= acc[c] + $signed({{LW{shifted[c][2*DW-1]}}, shifted[c]});
         end
         case (state)
            IDLE: if (start) begin
               len <= len_c;
               shift <= cfg_shift;
               map_cnt <= '0;
               fil_cnt <= '0;
               k <= '0;
               skip_count <= '0;
               for (int c = 0; c < NCH; c++) acc[c] <= '0;
               state <= len_c == '0 ? ACCU : LOAD;
            end
            LOAD: begin
               if (map_fire) map_cnt <= map_cnt + 1'b1;
               if (fil_fire) fil_cnt <= fil_cnt + 1'b1;
               if (map_cnt == len && fil_cnt == len) state <= MAC;
            end
            MAC: begin
               k <= k + 1'b1;
               if (issue && zero_tap) skip_count <= skip_count + 1'b1;
               // k == len is the drain cycle that lets the last product land
               if (k == len) state <= ACCU;
            end
            ACCU: if (psum_in_valid) begin
               for (int c = 0; c < NCH; c++) out_data[c*DW +: DW] <= narrowed[c];
               state <= OUT;
            end
            OUT: if (out_ready) begin
               done <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_eyeriss_pe_core_p.sv
// tb_eyeriss_pe_core_p: scoreboard bench; tasks queue expected results from an arithmetic model,
// a monitor pops them on every output handshake.
module tb_eyeriss_pe_core_p;
   localparam int DW = 16;
   localparam int NCH = 2;
   localparam int DEPTH = 12;
   localparam int LW = $clog2(DEPTH+1);
   typedef struct {
      logic [NCH*DW-1:0] sat;
      logic [NCH*DW-1:0] trunc;
      int skip;
   } exp_t;
   logic CLK = 0;
   logic clr = 1, start = 0, map_valid = 0, fil_valid = 0, psum_in_valid = 0, out_ready = 0;
   logic [LW-1:0] cfg_len = 0;
   logic [3:0] cfg_shift = 0;
   logic [DW-1:0] map_data = 0;
   logic [NCH*DW-1:0] fil_data = 0, psum_in = 0;
   logic map_ready, fil_ready, psum_in_ready, out_valid, busy, done;
   logic [NCH*DW-1:0] out_data;
   logic [LW-1:0] skip_count;
   logic map_ready0, fil_ready0, psum_in_ready0, out_valid0, busy0, done0;
   logic [NCH*DW-1:0] out_data0;
   logic [LW-1:0] skip_count0;
   int errors = 0, checks = 0;
   exp_t sb[$];
   logic signed [DW-1:0] mv [DEPTH];
   logic signed [DW-1:0] fv [NCH][DEPTH];
   logic signed [DW-1:0] pv [NCH];
   always #5 CLK = ~CLK;
   eyeriss_pe_core_p #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH), .SAT(1)) dut (
      .CLK(CLK), .clr(clr), .start(start), .cfg_len(cfg_len), .cfg_shift(cfg_shift),
      .map_valid(map_valid), .map_data(map_data), .map_ready(map_ready),
      .fil_valid(fil_valid), .fil_data(fil_data), .fil_ready(fil_ready),
      .psum_in_valid(psum_in_valid), .psum_in(psum_in), .psum_in_ready(psum_in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .busy(busy), .done(done), .skip_count(skip_count));
   // truncating twin driven by the same stimulus; it runs in lockstep with dut
   eyeriss_pe_core_p #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH), .SAT(0)) dut0 (
      .CLK(CLK), .clr(clr), .start(start), .cfg_len(cfg_len), .cfg_shift(cfg_shift),
      .map_valid(map_valid), .map_data(map_data), .map_ready(map_ready0),
      .fil_valid(fil_valid), .fil_data(fil_data), .fil_ready(fil_ready0),
      .psum_in_valid(psum_in_valid), .psum_in(psum_in), .psum_in_ready(psum_in_ready0),
      .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready),
      .busy(busy0), .done(done0), .skip_count(skip_count0));
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic logic [DW-1:0] narrow(input longint v, input bit sat);
      longint maxv = (longint'(1) <<< (DW-1)) - 1;
      longint minv = -(longint'(1) <<< (DW-1));
      longint r = sat ? (v > maxv ? maxv : v < minv ? minv : v) : v;
      return r[DW-1:0];
   endfunction
   function automatic exp_t model(input int len, input int sh);
      exp_t e;
      e.skip = 0;
      for (int k = 0; k < len; k++) if (mv[k] == 0) e.skip++;
      for (int c = 0; c < NCH; c++) begin
         longint a = 0;
         for (int k = 0; k < len; k++)
            if (mv[k] != 0) a += (longint'(mv[k]) * longint'(fv[c][k])) >>> sh;
         a += longint'(pv[c]);
         e.sat[c*DW +: DW] = narrow(a, 1);
         e.trunc[c*DW +: DW] = narrow(a, 0);
      end
      return e;
   endfunction
   task automatic idle_inputs();
      map_valid = 0;
      fil_valid = 0;
      psum_in_valid = 0;
   endtask
   task automatic run_task(input int len, input int sh, input int bp, input bit rnd, input int exp_lat, input int abort_at);
      int mi = 0, fi = 0, cyc = 0;
      bit mf, ff;
      if (abort_at == 0) sb.push_back(model(len, sh));
      cfg_len = LW'(len);
      cfg_shift = 4'(sh);
      start = 1;
      out_ready = 0;
      @(posedge CLK); #1;
      start = 0;
      while (!out_valid) begin
         map_valid = mi < len && (!rnd || $urandom_range(3) != 0);
         map_data = mv[mi < len ? mi : 0];
         fil_valid = fi < len && (!rnd || $urandom_range(3) != 0);
         for (int c = 0; c < NCH; c++) begin
            fil_data[c*DW +: DW] = fv[c][fi < len ? fi : 0];
            psum_in[c*DW +: DW] = pv[c];
         end
         psum_in_valid = !rnd || $urandom_range(1) != 0;
         @(negedge CLK);
         mf = map_valid && map_ready;
         ff = fil_valid && fil_ready;
         @(posedge CLK); #1;
         cyc++;
         if (mf) mi++;
         if (ff) fi++;
         if (abort_at != 0 && cyc == abort_at) begin
            clr = 1;
            start = 1;
            @(posedge CLK); #1;
            clr = 0;
            start = 0;
            idle_inputs();
            chk("abort_busy", busy, 0);
            chk("abort_out_valid", out_valid, 0);
            repeat (3) @(posedge CLK);
            #1;
            chk("abort_busy_later", busy, 0);
            return;
         end
         if (cyc > 400) begin
            chk("timeout_out_valid", out_valid, 1);
            break;
         end
      end
      idle_inputs();
      if (exp_lat >= 0) chk("latency", cyc, exp_lat);
      repeat (bp) @(posedge CLK);
      #1;
      out_ready = 1;
      @(posedge CLK); #1;
      out_ready = 0;
      @(posedge CLK); #1;
   endtask
   task automatic set_basic();
      for (int k = 0; k < 3; k++) begin
         mv[k] = DW'(k + 1);
         fv[0][k] = DW'(k + 4);
         fv[1][k] = 1;
      end
      pv[0] = 10;
      pv[1] = 20;
   endtask
   // monitor: scoreboard pops, backpressure stability and the done pulse
   initial begin
      logic [NCH*DW-1:0] held;
      bit hold_v = 0, done_exp = 0;
      exp_t e;
      forever begin
         @(negedge CLK);
         if (clr) begin
            hold_v = 0;
            done_exp = 0;
         end else begin
            if (done || done_exp) chk("done_pulse", done, done_exp);
            if (hold_v) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_data", out_data, held);
            end
            done_exp = 0;
            hold_v = 0;
            if (out_valid && out_ready) begin
               if (sb.size() == 0) chk("unexpected_output", 1, 0);
               else begin
                  e = sb.pop_front();
                  chk("out_sat", out_data, e.sat);
                  chk("out_trunc", out_data0, e.trunc);
                  chk("skip_count", skip_count, LW'(e.skip));
               end
               done_exp = 1;
            end else if (out_valid) begin
               hold_v = 1;
               held = out_data;
            end
         end
      end
   end
   initial begin
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_map_ready", map_ready, 0);
      chk("rst_fil_ready", fil_ready, 0);
      chk("rst_psum_ready", psum_in_ready, 0);
      chk("rst_skip", skip_count, 0);
      clr = 0;
      @(posedge CLK); #1;
      set_basic();
      run_task(3, 0, 0, 0, 9, 0);
      mv[0] = 0; mv[1] = 2; mv[2] = 0;
      fv[0][0] = 7; fv[0][1] = 3; fv[0][2] = 9;
      pv[0] = 0; pv[1] = 0;
      run_task(3, 0, 0, 0, 9, 0);
      mv[0] = 32767; fv[0][0] = 32767; fv[1][0] = -32768;
      run_task(1, 0, 0, 0, 5, 0);
      mv[0] = -8; fv[0][0] = 3; fv[1][0] = 0;
      run_task(1, 2, 0, 0, 5, 0);
      set_basic();
      run_task(3, 0, 5, 0, 9, 0);
      pv[0] = -5; pv[1] = 7;
      run_task(0, 0, 0, 0, 1, 0);
      set_basic();
      run_task(3, 0, 0, 0, -1, 6);
      run_task(3, 0, 0, 0, 9, 0);
      for (int t = 0; t < 40; t++) begin
         int len = $urandom_range(DEPTH);
         bit big = $urandom_range(1) != 0;
         for (int k = 0; k < DEPTH; k++) begin
            mv[k] = $urandom_range(2) == 0 ? '0 : big ? DW'($urandom) : DW'($urandom_range(15)) - 8;
            for (int c = 0; c < NCH; c++) fv[c][k] = big ? DW'($urandom) : DW'($urandom_range(15)) - 8;
         end
         for (int c = 0; c < NCH; c++) pv[c] = DW'($urandom);
         run_task(len, $urandom_range(15), $urandom_range(3), 1, -1, 0);
      end
      repeat (5) @(posedge CLK);
      #1;
      chk("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/eyeriss_pe_core_p.md
EYERISS_PE_CORE_P -- requirements
Module: eyeriss_pe_core_p

Interface
REQ-001 The module SHALL have the following parameters (name, default, meaning):
- DW, 16, data width of map, filter, psum and output words.
- NCH, 2, number of filter channels, each with its own accumulator.
- DEPTH, 12, scratchpad entries per map and per filter channel.
- SAT, 1, selects output narrowing: 1 = saturate, 0 = truncate.
- LW, $clog2(DEPTH+1), width of length fields.

REQ-002 The module SHALL have the following ports (name, direction, width, meaning):
- CLK, in, 1, single clock, rising edge.
- clr, in, 1, reset, synchronous and active-high.
- start, in, 1, begin a task; sampled only in IDLE.
- cfg_len, in, LW, number of taps, latched at start.
- cfg_shift, in, 4, product right-shift, latched at start.
- map_valid, in, 1, ifmap stream valid.
- map_data, in, DW, ifmap stream data.
- map_ready, out, 1, ifmap stream ready.
- fil_valid, in, 1, filter stream valid.
- fil_data, in, NCH*DW, filter stream data; channel c occupies bits [c*DW +: DW].
- fil_ready, out, 1, filter stream ready.
- psum_in_valid, in, 1, incoming psum valid.
- psum_in, in, NCH*DW, incoming psums.
- psum_in_ready, out, 1, incoming psum ready.
- out_valid, out, 1, result valid.
- out_data, out, NCH*DW, results.
- out_ready, in, 1, result ready.
- busy, out, 1, high in any state other than IDLE.
- done, out, 1, one-cycle end-of-task pulse.
- skip_count, out, LW, number of zero-gated taps in the last task.

REQ-003 All data words SHALL be two's-complement signed.

Function
REQ-010 The FSM states SHALL be IDLE, LOAD, MAC, ACCU and OUT.
REQ-011 IDLE SHALL move to LOAD on start=1, latching cfg_len and cfg_shift and zeroing the accumulators and skip_count; IDLE SHALL move directly to ACCU instead if cfg_len=0.
REQ-012 A start pulse outside IDLE SHALL be ignored.
REQ-013 LOAD handshakes:
- map_ready SHALL be high while map_cnt<len.
- fil_ready SHALL be high while fil_cnt<len.
- Each valid&ready cycle SHALL write its stream's entry at its own counter and increment that counter.
- The two streams SHALL be independent and may transfer in the same cycle.
REQ-014 LOAD SHALL move to MAC in the cycle after both counters equal len.
REQ-015 MAC SHALL issue one tap index k = 0..len-1 per cycle.
REQ-016 Each issued tap SHALL be registered as product = map[k]*fil[c][k], 2*DW bits, for every channel c.
REQ-017 One cycle after issue, each product SHALL be arithmetic-shifted right by cfg_shift and added into a 2*DW+LW-bit signed accumulator per channel.
REQ-018 Zero-skip: if map[k]=0, the multiplier inputs SHALL be gated to zero, the accumulators SHALL not change, and skip_count SHALL increment; the tap still takes one cycle.
REQ-019 MAC SHALL last exactly len+1 cycles (len issue cycles plus one drain cycle) and then move to ACCU.
REQ-020 ACCU SHALL hold psum_in_ready=1; on handshake it SHALL add sign-extended psum_in[c] to accumulator c, narrow the result to DW bits, register it into out_data, and move to OUT.
REQ-021 Narrowing with SAT=1 SHALL clamp to [-2^(DW-1), 2^(DW-1)-1]; with SAT=0 it SHALL keep the low DW bits.
REQ-022 OUT SHALL hold out_valid=1 with out_data stable until out_ready=1.
REQ-023 On the OUT handshake cycle the FSM SHALL move to IDLE, and done SHALL be high in the following cycle only.
REQ-024 Outside OUT, out_data SHALL keep its last value and out_valid SHALL be 0.
REQ-025 skip_count SHALL hold its value from the end of MAC until the next accepted start.
REQ-026 Minimum task latency from start to out_valid, with streams and psum always valid, SHALL be 1 + len (LOAD) + 1 + (len+1) (MAC) + 1 (ACCU) cycles.

Reset
REQ-030 While clr=1 at a rising edge:
- the FSM SHALL go to IDLE;
- counters, accumulators and skip_count SHALL be 0;
- out_data SHALL be 0;
- busy, done, out_valid, map_ready, fil_ready and psum_in_ready SHALL be 0.
REQ-031 A clr during any state SHALL abort the task without emitting done.
REQ-032 clr SHALL take priority over start arriving in the same cycle.
REQ-033 Scratchpad contents are not reset and are fully rewritten by each LOAD.

Verification
REQ-040 Test configuration is DW=16, NCH=2, DEPTH=12; scenarios:
- Basic: len=3, shift=0, map={1,2,3}, fil ch0={4,5,6}, ch1={1,1,1}, psum_in={10,20} -> out_data ch0=42, ch1=26; skip_count=0; done pulses once.
- Zero-skip: len=3, map={0,2,0}, fil ch0={7,3,9}, psum_in=0 -> ch0=6; skip_count=2; MAC lasts exactly 4 cycles.
- Saturation: len=1, map={32767}, fil={32767}, shift=0, psum_in=0 -> SAT=1: 0x7FFF; SAT=0: 0x0001.
- Shift/sign: len=1, map={-8}, fil={3}, shift=2 -> ch0=0xFFFA (-6).
- Backpressure: out_ready low for 5 cycles -> out_valid held high, out_data unchanged; done one cycle after the handshake.
- Edge cases:
  - cfg_len=0 with psum_in={-5,7} -> out {-5,7}, no LOAD/MAC cycles.
  - clr asserted mid-MAC -> busy=0 next cycle and no done; the Basic task rerun then gives the Basic result.
